iprf_wr_arb: RTL and testbench
==============================

Name: iprf_wr_arb

Overview:
- Arbitrates the single integer PRF write port between the integer execute completion stream (ex1) and the memory completion stream (mm5).
- Sits between exe/mem and the rename-stage iprf, and feeds the ROB result tracking.
- Per-source skid FIFOs absorb collisions. Fixed memory priority, with a starvation override for exe.
- Flushes all pending writes on a ROB nuke.

Parameters:
- SKID_DEPTH, 2, entries per source FIFO (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles an exe head may lose before it gets forced priority.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ex_valid_ex1  in  1  exe result valid
- ex_pkt_ex1  in  $bits(t_prf_wr_pkt)  exe result packet
- ex_ready_ex1  out  1  exe FIFO can accept
- mm_valid_mm5  in  1  mem result valid
- mm_pkt_mm5  in  $bits(t_prf_wr_pkt)  mem result packet
- mm_ready_mm5  out  1  mem FIFO can accept
- nuke_rb1  in  $bits(t_nuke_pkt)  ROB nuke; only .valid is used
- iprf_wr_valid_ro0  out  1  registered PRF write valid
- iprf_wr_pkt_ro0  out  $bits(t_prf_wr_pkt)  registered PRF write packet

Behaviour:
- Reset:
  - Both FIFOs empty; pointers and counts 0.
  - starve_cnt=0; state=PRI_MM.
  - iprf_wr_valid_ro0=0; iprf_wr_pkt_ro0='0.
  - ex_ready_ex1=1; mm_ready_mm5=1 (ready is combinational from count, so both are 1 whenever the FIFOs are empty).
- Handshake:
  - A push occurs when valid & ready.
  - ready = (count != SKID_DEPTH), computed from current count only; it never depends on a same-cycle pop.
  - valid while !ready is a protocol error: $error under SIMULATION, and the packet is dropped.
- Candidates:
  - The candidate for each source is its FIFO head if non-empty.
  - Otherwise it is the same-cycle input (bypass), if pushing into an empty FIFO.
  - A bypassed candidate that wins is not written into the FIFO.
- Latency: an input accepted at cycle N with no contention drives iprf_wr_valid_ro0 at N+1.
- Grant: one winner per cycle, registered into the ro0 flops. Losing candidates remain in (or enter) their FIFO.
- FSM:
  - PRI_MM: mm wins on conflict. Each cycle ex has a candidate and loses, starve_cnt increments (saturating). When starve_cnt reaches STARVE_LIMIT-1 on a loss, go to PRI_EX.
  - PRI_EX: ex wins on conflict. After the ex grant, go to PRI_MM and clear starve_cnt.
  - starve_cnt also clears whenever ex is granted or has no candidate.
- No-candidate cycle: iprf_wr_valid_ro0=0. The pkt flops hold their previous value.
- Simultaneous push and pop on a full FIFO: not permitted, because ready is 0 when full.
- Pointer arithmetic: pointers are $clog2(SKID_DEPTH) bits and wrap naturally. count is $clog2(SKID_DEPTH)+1 bits.
- Nuke: when nuke_rb1.valid=1 at cycle N:
  - Both FIFOs clear at N+1.
  - Same-cycle inputs are dropped.
  - No grant is made in cycle N, so iprf_wr_valid_ro0=0 at N+1.
  - starve_cnt=0; state=PRI_MM.
- Reset mid-operation has the same effect as the reset values above. Pending entries are discarded without a write.
- Ordering: within a source, writes leave strictly in FIFO order. There is no cross-source ordering guarantee.

Optional Feature:
- Macro IPRF_WR_ARB_STATS_EN.
- When defined, the block adds 32-bit saturating counters: ex_grants, mm_grants, conflict_cycles (both candidates present), starve_overrides (PRI_EX entries), nuke_drops (valid entries discarded by nuke).
  - They are exposed as outputs stat_ex_grants, stat_mm_grants, stat_conflicts, stat_starve, stat_nuke_drops.
  - They clear on reset.
- When undefined, the counters and ports do not exist, and arbitration is functionally identical.

Decomposition:
- Package mem_common gains:
  - t_wr_arb_src (SRC_EX, SRC_MM)
  - t_wr_arb_state (PRI_MM, PRI_EX)
  - IPRF_WR_SKID_DEPTH
  - IPRF_WR_STARVE_LIMIT
- t_prf_wr_pkt and t_nuke_pkt stay in their existing packages.
- One sub-module: wr_skid_fifo (parameterised depth and packet type; push/pop/flush; exposes head, count, empty, full). It is instantiated twice.

Test Plan:
- Lone exe: ex_valid at cycle 10 with data 0x1234 -> iprf_wr_valid_ro0=1 at cycle 11 with data 0x1234; FIFO count stays 0.
- Collision: ex 0xA and mm 0xB both at cycle 5 -> ro0 shows 0xB at cycle 6, then 0xA at cycle 7; ex_ready stays 1.
- Starvation: mm valid every cycle and ex valid at cycle 0 (STARVE_LIMIT=4) -> mm granted cycles 0-2, ex granted cycle 3 (visible at ro0 cycle 4), then mm resumes.
- Backpressure: hold mm valid continuously while ex valid for 3 consecutive cycles (SKID_DEPTH=2) -> ex_ready drops to 0 once count=2; no packet lost or reordered; exe packets drain in order.
- Nuke: 2 ex and 1 mm entries pending, nuke_rb1.valid at cycle 20 with a same-cycle ex input -> no write at 21; both FIFOs empty at 21; readies=1; the dropped input never appears.
- Reset mid-stream: reset asserted while FIFOs are full -> next cycle outputs valid=0, readies=1, state PRI_MM, stats (if enabled) 0.

Source files
------------

// File: rtl/iprf_wr_arb_pkg.sv
// Shared types and defaults for the integer PRF write-port arbiter.
// Optional statistics are enabled with the IPRF_WR_ARB_STATS_EN macro.
package iprf_wr_arb_pkg;

   localparam int unsigned PRF_TAG_W = 7;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned ROB_ID_W  = 7;

   typedef struct packed {
      logic [PRF_TAG_W-1:0] prd;
      logic [XLEN-1:0]      data;
   } t_prf_wr_pkt;

   typedef struct packed {
      logic                valid;
      logic [ROB_ID_W-1:0] rob_id;
   } t_nuke_pkt;

   typedef enum logic {SRC_EX, SRC_MM} t_wr_arb_src;
   typedef enum logic {PRI_MM, PRI_EX} t_wr_arb_state;

   localparam int unsigned IPRF_WR_SKID_DEPTH   = 2;
   localparam int unsigned IPRF_WR_STARVE_LIMIT = 4;

   // Saturating 32-bit add for event counters
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? '1 : sum[31:0];
   endfunction

endpackage

// File: rtl/iprf_wr_arb_if.sv
// Bundle of the exe/mem completion streams, ROB nuke and PRF write port.
// Statistics outputs exist only when IPRF_WR_ARB_STATS_EN is defined.
interface iprf_wr_arb_if;
   import iprf_wr_arb_pkg::*;

   logic        ex_valid_ex1;
   t_prf_wr_pkt ex_pkt_ex1;
   logic        ex_ready_ex1;
   logic        mm_valid_mm5;
   t_prf_wr_pkt mm_pkt_mm5;
   logic        mm_ready_mm5;
   t_nuke_pkt   nuke_rb1;
   logic        iprf_wr_valid_ro0;
   t_prf_wr_pkt iprf_wr_pkt_ro0;
`ifdef IPRF_WR_ARB_STATS_EN
   logic [31:0] stat_ex_grants;
   logic [31:0] stat_mm_grants;
   logic [31:0] stat_conflicts;
   logic [31:0] stat_starve;
   logic [31:0] stat_nuke_drops;
`endif

   modport master (
      output ex_valid_ex1, ex_pkt_ex1, mm_valid_mm5, mm_pkt_mm5, nuke_rb1,
      input  ex_ready_ex1, mm_ready_mm5, iprf_wr_valid_ro0, iprf_wr_pkt_ro0
`ifdef IPRF_WR_ARB_STATS_EN
      , input stat_ex_grants, stat_mm_grants, stat_conflicts, stat_starve, stat_nuke_drops
`endif
   );

   modport slave (
      input  ex_valid_ex1, ex_pkt_ex1, mm_valid_mm5, mm_pkt_mm5, nuke_rb1,
      output ex_ready_ex1, mm_ready_mm5, iprf_wr_valid_ro0, iprf_wr_pkt_ro0
`ifdef IPRF_WR_ARB_STATS_EN
      , output stat_ex_grants, stat_mm_grants, stat_conflicts, stat_starve, stat_nuke_drops
`endif
   );

endinterface

// File: rtl/iprf_wr_arb_wr_skid_fifo.sv
// Small circular skid FIFO with push/pop/flush; head is the oldest entry.
module wr_skid_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter type         PKT_T = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  PKT_T                   push_pkt,
   input  logic                   pop,
   output PKT_T                   head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   PKT_T             mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [PTR_W:0]   count_q;

   // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read when counted as valid
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_pkt;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/iprf_wr_arb.sv
// Integer PRF write-port arbiter: mem has fixed priority, exe gets a forced
// win after repeated losses. Stats counters under IPRF_WR_ARB_STATS_EN.
module iprf_wr_arb
   import iprf_wr_arb_pkg::*;
#(
   parameter int unsigned SKID_DEPTH   = IPRF_WR_SKID_DEPTH,
   parameter int unsigned STARVE_LIMIT = IPRF_WR_STARVE_LIMIT
) (
   input logic          clk,
   input logic          reset,
   iprf_wr_arb_if.slave bus
);

   localparam int unsigned CNT_W    = $clog2(SKID_DEPTH) + 1;
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT) + 1;
   localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT - 1);
   // A loss at this count brings the counter to STARVE_MAX and flips priority
   localparam logic [STARVE_W-1:0] STARVE_TRIG = STARVE_W'(STARVE_LIMIT - 2);

   logic             nuke;
   t_prf_wr_pkt      ex_head, mm_head, ex_cand_pkt, mm_cand_pkt;
   logic [CNT_W-1:0] ex_count, mm_count;
   logic             ex_empty, ex_full, mm_empty, mm_full;
   logic             ex_push_req, mm_push_req, ex_push, mm_push, ex_pop, mm_pop;
   logic             ex_cand, mm_cand, grant_valid, grant_ex, grant_mm, ex_lose;
   t_wr_arb_src      grant_src;
   t_wr_arb_state    state_q, state_d;
   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             wr_valid_q;
   t_prf_wr_pkt      wr_pkt_q;
   logic             unused_sigs;

   assign nuke = bus.nuke_rb1.valid;

   assign bus.ex_ready_ex1 = !ex_full;
   assign bus.mm_ready_mm5 = !mm_full;

   // Inputs arriving during a nuke, or while not ready, are dropped
   assign ex_push_req = bus.ex_valid_ex1 & !ex_full & !nuke;
   assign mm_push_req = bus.mm_valid_mm5 & !mm_full & !nuke;

   // FIFO head if present, else same-cycle bypass of the incoming packet
   assign ex_cand     = !ex_empty | ex_push_req;
   assign mm_cand     = !mm_empty | mm_push_req;
   assign ex_cand_pkt = ex_empty ? bus.ex_pkt_ex1 : ex_head;
   assign mm_cand_pkt = mm_empty ? bus.mm_pkt_mm5 : mm_head;

   assign grant_ex = grant_valid & (grant_src == SRC_EX);
   assign grant_mm = grant_valid & (grant_src == SRC_MM);
   assign ex_lose  = ex_cand & !grant_ex;

   // A winning bypass candidate skips the FIFO entirely
   assign ex_pop  = grant_ex & !ex_empty;
   assign mm_pop  = grant_mm & !mm_empty;
   assign ex_push = ex_push_req & !(grant_ex & ex_empty);
   assign mm_push = mm_push_req & !(grant_mm & mm_empty);

   wr_skid_fifo #(.DEPTH(SKID_DEPTH), .PKT_T(t_prf_wr_pkt)) u_ex_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (nuke),
      .push     (ex_push),
      .push_pkt (bus.ex_pkt_ex1),
      .pop      (ex_pop),
      .head     (ex_head),
      .count    (ex_count),
      .empty    (ex_empty),
      .full     (ex_full)
   );

   wr_skid_fifo #(.DEPTH(SKID_DEPTH), .PKT_T(t_prf_wr_pkt)) u_mm_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (nuke),
      .push     (mm_push),
      .push_pkt (bus.mm_pkt_mm5),
      .pop      (mm_pop),
      .head     (mm_head),
      .count    (mm_count),
      .empty    (mm_empty),
      .full     (mm_full)
   );

   // Priority state and starvation counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= PRI_MM;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Next priority state from the current grant outcome
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      if (nuke) begin
         state_d      = PRI_MM;
         starve_cnt_d = '0;
      end else begin
         unique case (state_q)
            PRI_MM: begin
               if (ex_lose) begin
                  if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                  if (starve_cnt_q == STARVE_TRIG) state_d = PRI_EX;
               end else begin
                  starve_cnt_d = '0;
               end
            end
            PRI_EX: begin
               if (grant_ex || !ex_cand) begin
                  state_d      = PRI_MM;
                  starve_cnt_d = '0;
               end
            end
         endcase
      end
   end

   // Grant selection: one winner per cycle, none during a nuke
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_MM;
      if (!nuke) begin
         if (ex_cand && mm_cand) begin
            grant_valid = 1'b1;
            grant_src   = (state_q == PRI_EX) ? SRC_EX : SRC_MM;
         end else if (ex_cand) begin
            grant_valid = 1'b1;
            grant_src   = SRC_EX;
         end else if (mm_cand) begin
            grant_valid = 1'b1;
            grant_src   = SRC_MM;
         end
      end
   end

   // Registered PRF write; packet holds its last value on idle cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_valid_q <= 1'b0;
         wr_pkt_q   <= '0;
      end else begin
         wr_valid_q <= grant_valid;
         if (grant_valid) wr_pkt_q <= grant_ex ? ex_cand_pkt : mm_cand_pkt;
      end
   end

   assign bus.iprf_wr_valid_ro0 = wr_valid_q;
   assign bus.iprf_wr_pkt_ro0   = wr_pkt_q;

`ifdef SIMULATION
   // Valid while not ready violates the handshake; the packet is dropped
   always_ff @(posedge clk) begin
      if (!reset && bus.ex_valid_ex1 && ex_full) $error("iprf_wr_arb: ex push while full");
      if (!reset && bus.mm_valid_mm5 && mm_full) $error("iprf_wr_arb: mm push while full");
   end
`endif

`ifdef IPRF_WR_ARB_STATS_EN
   logic [31:0] stat_ex_q, stat_mm_q, stat_conf_q, stat_starve_q, stat_nuke_q;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_ex_q     <= '0;
         stat_mm_q     <= '0;
         stat_conf_q   <= '0;
         stat_starve_q <= '0;
         stat_nuke_q   <= '0;
      end else begin
         if (grant_ex) stat_ex_q <= sat_add32(stat_ex_q, 32'd1);
         if (grant_mm) stat_mm_q <= sat_add32(stat_mm_q, 32'd1);
         if (!nuke && ex_cand && mm_cand) stat_conf_q <= sat_add32(stat_conf_q, 32'd1);
         if (state_q == PRI_MM && state_d == PRI_EX) begin
            stat_starve_q <= sat_add32(stat_starve_q, 32'd1);
         end
         if (nuke) stat_nuke_q <= sat_add32(stat_nuke_q, 32'(ex_count) + 32'(mm_count));
      end
   end

   assign bus.stat_ex_grants  = stat_ex_q;
   assign bus.stat_mm_grants  = stat_mm_q;
   assign bus.stat_conflicts  = stat_conf_q;
   assign bus.stat_starve     = stat_starve_q;
   assign bus.stat_nuke_drops = stat_nuke_q;
`endif

   assign unused_sigs = ^{bus.nuke_rb1.rob_id, ex_count, mm_count};

endmodule

// File: tb/tb_iprf_wr_arb.sv
// Self-checking bench for iprf_wr_arb: cycle vectors with a scoreboard of
// expected ro0 writes, plus a hand-written reset-mid-stream sequence.
module tb_iprf_wr_arb;
   import iprf_wr_arb_pkg::*;

   typedef struct {
      logic        ev;
      logic [31:0] ed;
      logic        mv;
      logic [31:0] md;
      logic        nk;
      logic        xv;   // expected iprf_wr_valid_ro0 after this cycle
      logic [31:0] xd;   // expected data when xv
      logic        xer;  // expected ex_ready this cycle
      logic        xmr;  // expected mm_ready this cycle
   } vec_t;

   typedef struct {
      logic        v;
      t_prf_wr_pkt pkt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          passed = 0;
   int          total = 0;
   vec_t        vecs[$];
   exp_t        sb[$];
   t_prf_wr_pkt last_pkt = '0;

   iprf_wr_arb_if bus ();

   iprf_wr_arb #(.SKID_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic t_prf_wr_pkt mk(input logic [31:0] d);
      t_prf_wr_pkt p;
      p.prd  = d[6:0];
      p.data = d;
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %0h want %0h", name, act, want);
   endtask

   task automatic add(input logic ev, input logic [31:0] ed, input logic mv, input logic [31:0] md,
                      input logic nk, input logic xv, input logic [31:0] xd,
                      input logic xer, input logic xmr);
      vec_t v;
      v.ev = ev; v.ed = ed; v.mv = mv; v.md = md; v.nk = nk;
      v.xv = xv; v.xd = xd; v.xer = xer; v.xmr = xmr;
      vecs.push_back(v);
   endtask

   // One cycle: check readies, drive inputs, queue expectation, sample after the edge
   task automatic step(input logic rst, input vec_t v, input string tag);
      exp_t e, got;
      check({tag, " ex_ready"}, 64'(bus.ex_ready_ex1), 64'(v.xer));
      check({tag, " mm_ready"}, 64'(bus.mm_ready_mm5), 64'(v.xmr));
      reset            = rst;
      bus.ex_valid_ex1 = v.ev;
      bus.ex_pkt_ex1   = mk(v.ed);
      bus.mm_valid_mm5 = v.mv;
      bus.mm_pkt_mm5   = mk(v.md);
      bus.nuke_rb1     = '{valid: v.nk, rob_id: 7'd0};
      if (rst) last_pkt = '0;
      else if (v.xv) last_pkt = mk(v.xd);
      e.v   = v.xv & !rst;
      e.pkt = last_pkt;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      reset            = 1'b0;
      bus.ex_valid_ex1 = 1'b0;
      bus.mm_valid_mm5 = 1'b0;
      bus.nuke_rb1     = '0;
      got = sb.pop_front();
      check({tag, " wr_valid"}, 64'(bus.iprf_wr_valid_ro0), 64'(got.v));
      check({tag, " wr_pkt"}, 64'(bus.iprf_wr_pkt_ro0), 64'(got.pkt));
   endtask

   function automatic vec_t mkv(input logic ev, input logic [31:0] ed, input logic mv,
                                input logic [31:0] md, input logic xv, input logic [31:0] xd,
                                input logic xer, input logic xmr);
      vec_t v;
      v.ev = ev; v.ed = ed; v.mv = mv; v.md = md; v.nk = 1'b0;
      v.xv = xv; v.xd = xd; v.xer = xer; v.xmr = xmr;
      return v;
   endfunction

`ifdef IPRF_WR_ARB_STATS_EN
   task automatic check_stats_zero(input string tag);
      check({tag, " stat_ex"}, 64'(bus.stat_ex_grants), 64'd0);
      check({tag, " stat_mm"}, 64'(bus.stat_mm_grants), 64'd0);
      check({tag, " stat_conf"}, 64'(bus.stat_conflicts), 64'd0);
      check({tag, " stat_starve"}, 64'(bus.stat_starve), 64'd0);
      check({tag, " stat_nuke"}, 64'(bus.stat_nuke_drops), 64'd0);
   endtask
`endif

   initial begin
      bus.ex_valid_ex1 = 1'b0;
      bus.ex_pkt_ex1   = '0;
      bus.mm_valid_mm5 = 1'b0;
      bus.mm_pkt_mm5   = '0;
      bus.nuke_rb1     = '0;

      //   ev ed          mv md          nk xv xd          xer xmr
      // lone exe
      add(1, 32'h1234, 0, 0,        0, 1, 32'h1234, 1, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);
      // collision: mm first, then queued ex
      add(1, 32'hA,    1, 32'hB,    0, 1, 32'hB,    1, 1);
      add(0, 0,        0, 0,        0, 1, 32'hA,    1, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);
      // starvation: three mm wins, forced ex win, mm resumes
      add(1, 32'h10,   1, 32'h20,   0, 1, 32'h20,   1, 1);
      add(0, 0,        1, 32'h21,   0, 1, 32'h21,   1, 1);
      add(0, 0,        1, 32'h22,   0, 1, 32'h22,   1, 1);
      add(0, 0,        1, 32'h23,   0, 1, 32'h10,   1, 1);
      add(0, 0,        1, 32'h24,   0, 1, 32'h23,   1, 1);
      add(0, 0,        0, 0,        0, 1, 32'h24,   1, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);
      // backpressure: ex FIFO fills, ex_ready drops, exe drains in order
      add(1, 32'h30,   1, 32'h40,   0, 1, 32'h40,   1, 1);
      add(1, 32'h31,   1, 32'h41,   0, 1, 32'h41,   1, 1);
      add(0, 0,        1, 32'h42,   0, 1, 32'h42,   0, 1);
      add(0, 0,        1, 32'h43,   0, 1, 32'h30,   0, 1);
      add(1, 32'h32,   1, 32'h44,   0, 1, 32'h43,   1, 1);
      add(0, 0,        1, 32'h45,   0, 1, 32'h44,   0, 1);
      add(0, 0,        1, 32'h46,   0, 1, 32'h45,   0, 1);
      add(0, 0,        1, 32'h47,   0, 1, 32'h31,   0, 1);
      add(0, 0,        0, 0,        0, 1, 32'h46,   1, 0);
      add(0, 0,        0, 0,        0, 1, 32'h47,   1, 1);
      add(0, 0,        0, 0,        0, 1, 32'h32,   1, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);
      // nuke with ex 51,52 and mm 64 pending plus a same-cycle mm input
      add(1, 32'h50,   1, 32'h60,   0, 1, 32'h60,   1, 1);
      add(1, 32'h51,   1, 32'h61,   0, 1, 32'h61,   1, 1);
      add(0, 0,        1, 32'h62,   0, 1, 32'h62,   0, 1);
      add(0, 0,        1, 32'h63,   0, 1, 32'h50,   0, 1);
      add(1, 32'h52,   1, 32'h64,   0, 1, 32'h63,   1, 1);
      add(0, 0,        1, 32'h99,   1, 0, 0,        0, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);
      // nuke with a same-cycle ex input into an empty FIFO
      add(1, 32'h77,   0, 0,        1, 0, 0,        1, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);
      // priority back to mm after nuke
      add(1, 32'h80,   1, 32'h81,   0, 1, 32'h81,   1, 1);
      add(0, 0,        0, 0,        0, 1, 32'h80,   1, 1);
      add(0, 0,        0, 0,        0, 0, 0,        1, 1);

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst wr_valid", 64'(bus.iprf_wr_valid_ro0), 64'd0);
      check("rst wr_pkt", 64'(bus.iprf_wr_pkt_ro0), 64'd0);
      check("rst ex_ready", 64'(bus.ex_ready_ex1), 64'd1);
      check("rst mm_ready", 64'(bus.mm_ready_mm5), 64'd1);
`ifdef IPRF_WR_ARB_STATS_EN
      check_stats_zero("rst");
`endif
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(1'b0, vecs[i], $sformatf("vec%0d", i));
      end

      // reset mid-stream with a full ex FIFO; starvation count must restart at 0
      step(1'b0, mkv(1, 32'h90, 1, 32'h91, 1, 32'h91, 1, 1), "mid0");
      step(1'b0, mkv(1, 32'h92, 1, 32'h93, 1, 32'h93, 1, 1), "mid1");
      step(1'b1, mkv(0, 0,      1, 32'h94, 0, 0,      0, 1), "mid_rst");
`ifdef IPRF_WR_ARB_STATS_EN
      check_stats_zero("mid_rst");
`endif
      step(1'b0, mkv(1, 32'hA1, 1, 32'hB1, 1, 32'hB1, 1, 1), "mid3");
      step(1'b0, mkv(0, 0,      1, 32'hB2, 1, 32'hB2, 1, 1), "mid4");
      step(1'b0, mkv(0, 0,      1, 32'hB3, 1, 32'hB3, 1, 1), "mid5");
      step(1'b0, mkv(0, 0,      1, 32'hB4, 1, 32'hA1, 1, 1), "mid6");
      step(1'b0, mkv(0, 0,      0, 0,      1, 32'hB4, 1, 1), "mid7");
      step(1'b0, mkv(0, 0,      0, 0,      0, 0,      1, 1), "mid8");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
